// File: rtl/bnn_layer_sequencer.sv
// Scheduler for the chained BNN layer stages: enables stages in order as a thermometer code,
// keeps finished stages enabled, detects hung stages and reports result/error to the host.
module bnn_layer_sequencer #(
    parameter int NUM_STAGES     = 5,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int LAT_W          = 16,
    localparam int CS_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  result_ack,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_run,
    output logic                  busy,
    output logic                  result_valid,
    output logic                  error,
    output logic [CS_W-1:0]       cur_stage,
    output logic [LAT_W-1:0]      latency,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [CS_W-1:0]  LAST_STAGE = CS_W'(NUM_STAGES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [NUM_STAGES-1:0]   stage_run_q, stage_run_d;
    logic [CS_W-1:0]         cur_stage_q, cur_stage_d;
    logic [LAT_W-1:0]        latency_q, latency_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic                    first_q, first_d;
    logic                    busy_q, busy_d;
    logic                    valid_q, valid_d;
    logic                    error_q, error_d;
    logic                    cur_done;

    // Bits [idx:0] set: every stage up to and including idx stays enabled.
    function automatic logic [NUM_STAGES-1:0] therm(input logic [CS_W-1:0] idx);
        logic [NUM_STAGES-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            v[i] = (i <= int'(idx));
        end
        return v;
    endfunction

    // first_q masks the done flag during the cycle the stage's enable rose,
    // since the stage may still be presenting a stale done from its previous run.
    assign cur_done = stage_done[cur_stage_q] & ~first_q;

    always_comb begin
        state_d     = state_q;
        stage_run_d = stage_run_q;
        cur_stage_d = cur_stage_q;
        latency_d   = latency_q;
        tmo_d       = tmo_q;
        first_d     = first_q;

        case (state_q)
            S_IDLE: begin
                stage_run_d = '0;
                if (start) begin
                    state_d     = S_RUN;
                    cur_stage_d = '0;
                    stage_run_d = therm('0);
                    latency_d   = '0;
                    tmo_d       = '0;
                    first_d     = 1'b1;
                end
            end
            S_RUN: begin
                if (latency_q != {LAT_W{1'b1}}) begin
                    latency_d = latency_q + LAT_W'(1);
                end
                if (abort) begin
                    state_d     = S_IDLE;
                    stage_run_d = '0;
                end else if (cur_done) begin
                    if (cur_stage_q == LAST_STAGE) begin
                        state_d = S_DONE;
                    end else begin
                        cur_stage_d = cur_stage_q + CS_W'(1);
                        stage_run_d = therm(cur_stage_q + CS_W'(1));
                        tmo_d       = '0;
                        first_d     = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d     = S_ERR;
                    stage_run_d = '0;
                end else begin
                    tmo_d   = tmo_q + TMO_W'(1);
                    first_d = 1'b0;
                end
            end
            S_DONE: begin
                if (result_ack || abort) begin
                    state_d     = S_IDLE;
                    stage_run_d = '0;
                end
            end
            S_ERR: begin
                stage_run_d = '0;
                if (result_ack || abort) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                stage_run_d = '0;
            end
        endcase

        busy_d  = (state_d == S_RUN);
        valid_d = (state_d == S_DONE);
        error_d = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            stage_run_q <= '0;
            cur_stage_q <= '0;
            latency_q   <= '0;
            tmo_q       <= '0;
            first_q     <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_run_q <= stage_run_d;
            cur_stage_q <= cur_stage_d;
            latency_q   <= latency_d;
            tmo_q       <= tmo_d;
            first_q     <= first_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
        end
    end

    assign stage_run    = stage_run_q;
    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign error        = error_q;
    assign cur_stage    = cur_stage_q;
    assign latency      = latency_q;
    assign dbg_state    = state_q;

endmodule
